// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming Sobel edge pipeline.
package sobel_pkg;

  // Output formatting mode carried with each window.
  typedef enum logic [1:0] {
    BIN     = 2'd0,
    CLIP    = 2'd1,
    SCALE   = 2'd2,
    BIN_ALT = 2'd3
  } mode_e;

  // Quantised gradient direction.
  typedef enum logic [1:0] {
    HORIZ_GRAD = 2'd0,
    VERT_GRAD  = 2'd1,
    DIAG_POS   = 2'd2,
    DIAG_NEG   = 2'd3
  } dir_e;

  // Right shift used by the scaled-magnitude output mode.
  localparam int SCALE_SHIFT = 3;

  // Gradient width: |Gx| and |Gy| are at most 4*(2^pix_w-1), so the
  // signed gradients and the unsigned magnitude both fit in pix_w+3 bits.
  function automatic int g_w(input int pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_pipe_slice.sv
// One elastic register stage: valid/ready handshake around a payload struct.
// The stage accepts new data when it is empty or its content leaves this cycle.
module sobel_pipe_slice #(
  parameter type payload_t = logic [7:0]
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  logic     valid_q, valid_d;
  payload_t data_q, data_d;

  // Next-state: load on input handshake, otherwise hold or drain.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_valid && in_ready) ? in_data : data_q;
  end

  // Stage register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage samples
    // its neighbour's pre-edge value; blocking here would collapse the pipeline.
    if (!rst_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset as well because the last stage drives the
      // output pixel and direction directly, and those must read 0 after reset.
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/sobel_edge_pipe.sv
// Streaming 3x3 Sobel edge operator: gradient, magnitude/direction and output
// formatting in three elastic stages, plus a saturating edge counter.
module sobel_edge_pipe
  import sobel_pkg::*;
#(
  parameter  int PIX_W = 8,
  parameter  int CNT_W = 24,
  localparam int G_W   = g_w(PIX_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [9*PIX_W-1:0] s_win,
  input  logic [1:0]         cfg_mode,
  input  logic [G_W-1:0]     cfg_thresh,
  input  logic               clr_cnt,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [PIX_W-1:0]   m_pixel,
  output logic [1:0]         m_dir,
  output logic [CNT_W-1:0]   edge_count
);

  // Gradients are kept as raw two's-complement bit patterns; the MSB is the sign.
  typedef struct packed {
    logic [G_W-1:0] gx;
    logic [G_W-1:0] gy;
    mode_e          mode;
    logic [G_W-1:0] thresh;
  } s1_t;

  typedef struct packed {
    logic [G_W-1:0] mag;
    dir_e           dir;
    mode_e          mode;
    logic [G_W-1:0] thresh;
  } s2_t;

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    dir_e             dir;
    logic             edge_f;
  } s3_t;

  s1_t s1_in, s1_out;
  s2_t s2_in, s2_out;
  s3_t s3_in, s3_out;

  logic s1_valid, s2_valid, s3_valid;
  logic s2_ready, s3_ready;

  logic [G_W-1:0] p11, p12, p13, p21, p23, p31, p32, p33;
  logic [G_W-1:0] ax, ay;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The centre pixel has a zero coefficient in both kernels.
  logic unused_center;
  assign unused_center = &{1'b0, s_win[4*PIX_W +: PIX_W]};

  // Stage 1 input: Sobel gradients of the incoming window, with its config.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path (defaults or
    // full assignment) so no latch is inferred.
    p11 = G_W'(s_win[0*PIX_W +: PIX_W]);
    p12 = G_W'(s_win[1*PIX_W +: PIX_W]);
    p13 = G_W'(s_win[2*PIX_W +: PIX_W]);
    p21 = G_W'(s_win[3*PIX_W +: PIX_W]);
    p23 = G_W'(s_win[5*PIX_W +: PIX_W]);
    p31 = G_W'(s_win[6*PIX_W +: PIX_W]);
    p32 = G_W'(s_win[7*PIX_W +: PIX_W]);
    p33 = G_W'(s_win[8*PIX_W +: PIX_W]);
    s1_in.gx     = (p13 + (p23 << 1) + p33) - (p11 + (p21 << 1) + p31);
    s1_in.gy     = (p11 + (p12 << 1) + p13) - (p31 + (p32 << 1) + p33);
    s1_in.mode   = mode_e'(cfg_mode);
    s1_in.thresh = cfg_thresh;
  end

  // Stage 2 input: L1 magnitude and direction bin from the gradients.
  always_comb begin
    ax = s1_out.gx[G_W-1] ? -s1_out.gx : s1_out.gx;
    ay = s1_out.gy[G_W-1] ? -s1_out.gy : s1_out.gy;
    s2_in.mag    = ax + ay;
    s2_in.mode   = s1_out.mode;
    s2_in.thresh = s1_out.thresh;
    // Zero gradients land in HORIZ_GRAD; the sign test is only reached when
    // both gradients are non-zero.
    if ({1'b0, ax} >= {ay, 1'b0})
      s2_in.dir = HORIZ_GRAD;
    else if ({1'b0, ay} >= {ax, 1'b0})
      s2_in.dir = VERT_GRAD;
    else if (s1_out.gx[G_W-1] == s1_out.gy[G_W-1])
      s2_in.dir = DIAG_POS;
    else
      s2_in.dir = DIAG_NEG;
  end

  // Stage 3 input: format the output pixel according to the captured mode.
  always_comb begin
    s3_in.dir    = s2_out.dir;
    s3_in.edge_f = s2_out.mag > s2_out.thresh;
    s3_in.pixel  = '0;
    case (s2_out.mode)
      BIN, BIN_ALT: s3_in.pixel = s3_in.edge_f ? '1 : '0;
      CLIP:         s3_in.pixel = (s2_out.mag[G_W-1:PIX_W] != '0) ? '1 : s2_out.mag[PIX_W-1:0];
      SCALE:        s3_in.pixel = s2_out.mag[PIX_W+SCALE_SHIFT-1:SCALE_SHIFT];
      default:      s3_in.pixel = '0;
    endcase
  end

  sobel_pipe_slice #(.payload_t(s1_t)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  sobel_pipe_slice #(.payload_t(s2_t)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (s3_ready),
    .out_data  (s2_out)
  );

  sobel_pipe_slice #(.payload_t(s3_t)) u_s3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s2_valid),
    .in_ready  (s3_ready),
    .in_data   (s3_in),
    .out_valid (s3_valid),
    .out_ready (m_ready),
    .out_data  (s3_out)
  );

  assign m_valid = s3_valid;
  assign m_pixel = s3_out.pixel;
  assign m_dir   = s3_out.dir;

  // Edge counter next-state: clear wins, otherwise count edges leaving the block.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = '0;
    else if (m_valid && m_ready && s3_out.edge_f && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Edge counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign edge_count = cnt_q;

endmodule

// File: tb/tb_sobel_edge_pipe.sv
// Self-checking bench for sobel_edge_pipe: directed cases plus randomized
// traffic, scored against a plain-arithmetic Sobel model through a queue.
module tb_sobel_edge_pipe;

  localparam int PIX_W = 8;
  localparam int CNT_W = 24;
  localparam int G_W   = PIX_W + 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               s_valid;
  logic               s_ready;
  logic [9*PIX_W-1:0] s_win;
  logic [1:0]         cfg_mode;
  logic [G_W-1:0]     cfg_thresh;
  logic               clr_cnt;
  logic               m_valid;
  logic               m_ready;
  logic [PIX_W-1:0]   m_pixel;
  logic [1:0]         m_dir;
  logic [CNT_W-1:0]   edge_count;

  typedef struct {
    int pix;
    int dir;
    bit edge_f;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   model_cnt = 0;
  bit   held_v = 0;
  int   held_pix, held_dir;
  bit   rnd_done;

  sobel_edge_pipe #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_win      (s_win),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .clr_cnt    (clr_cnt),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_pixel    (m_pixel),
    .m_dir      (m_dir),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: Sobel operator straight from the arithmetic definition.
  function automatic exp_t ref_model(input logic [9*PIX_W-1:0] w, input logic [1:0] mode,
                                     input logic [G_W-1:0] th);
    int p[9];
    int gx, gy, ax, ay, mag;
    exp_t e;
    for (int i = 0; i < 9; i++) p[i] = int'(w[i*PIX_W +: PIX_W]);
    gx  = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy  = (p[0] + 2*p[1] + p[2]) - (p[6] + 2*p[7] + p[8]);
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    if (ax >= 2*ay)               e.dir = 0;
    else if (ay >= 2*ax)          e.dir = 1;
    else if ((gx < 0) == (gy < 0)) e.dir = 2;
    else                          e.dir = 3;
    e.edge_f = (mag > int'(th));
    case (mode)
      2'd1:    e.pix = (mag > 255) ? 255 : mag;
      2'd2:    e.pix = mag / 8;
      default: e.pix = e.edge_f ? 255 : 0;
    endcase
    return e;
  endfunction

  function automatic logic [9*PIX_W-1:0] mk(input int a11, a12, a13, a21, a22, a23,
                                             a31, a32, a33);
    return {8'(a33), 8'(a32), 8'(a31), 8'(a23), 8'(a22), 8'(a21), 8'(a13), 8'(a12), 8'(a11)};
  endfunction

  // Input-side scoreboard feed: record the expected result on every accepted window.
  always @(negedge clk) begin
    if (rst_n && s_valid && s_ready) sb.push_back(ref_model(s_win, cfg_mode, cfg_thresh));
  end

  // Output monitor: compare emitted pixels, stall stability and the edge counter.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      model_cnt = 0;
      held_v    = 0;
    end else begin
      check("edge_count", int'(edge_count), model_cnt);
      if (held_v) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_pixel", int'(m_pixel), held_pix);
        check("stall_dir", int'(m_dir), held_dir);
      end
      held_v = 0;
      if (m_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: pixel %0d dir %0d with empty scoreboard at %0t",
                   m_pixel, m_dir, $time);
        end else if (m_ready) begin
          e = sb.pop_front();
          check("m_pixel", int'(m_pixel), e.pix);
          check("m_dir", int'(m_dir), e.dir);
          if (e.edge_f && model_cnt != (1 << CNT_W) - 1) model_cnt++;
        end else begin
          held_v   = 1;
          held_pix = int'(m_pixel);
          held_dir = int'(m_dir);
        end
      end
      if (clr_cnt) model_cnt = 0;
    end
  end

  // Present one window and hold it until the block accepts it.
  task automatic send(input logic [9*PIX_W-1:0] w, input logic [1:0] m, input logic [G_W-1:0] t);
    bit ok = 0;
    s_valid = 1'b1; s_win = w; cfg_mode = m; cfg_thresh = t;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: s_ready stayed 0 for 200 cycles at %0t", $time);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (sb.size() == 0) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout: %0d outputs still outstanding at %0t", sb.size(), $time);
    end
    @(posedge clk); #1;
  endtask

  logic [9*PIX_W-1:0] w_step, w_flat, w_diag, w_thr;
  int cnt_before;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_win = '0; cfg_mode = 2'd0; cfg_thresh = 11'd350;
    clr_cnt = 1'b0; m_ready = 1'b1;
    w_step = mk(0, 128, 255, 0, 128, 255, 0, 128, 255);
    w_flat = mk(100, 100, 100, 100, 100, 100, 100, 100, 100);
    w_diag = mk(0, 0, 200, 0, 200, 200, 200, 200, 200);
    w_thr  = mk(0, 0, 0, 0, 0, 175, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_m_valid", int'(m_valid), 0);
    check("reset_s_ready", int'(s_ready), 1);
    check("reset_m_pixel", int'(m_pixel), 0);
    check("reset_m_dir", int'(m_dir), 0);
    check("reset_edge_count", int'(edge_count), 0);
    @(posedge clk); #1;

    // Vertical step with latency measurement.
    send(w_step, 2'd0, 11'd350);
    @(negedge clk); check("lat_cycle1", int'(m_valid), 0);
    @(negedge clk); check("lat_cycle2", int'(m_valid), 0);
    @(negedge clk); check("lat_cycle3", int'(m_valid), 1);
    @(posedge clk); #1;
    send(w_step, 2'd1, 11'd350);
    send(w_step, 2'd2, 11'd350);
    send(w_flat, 2'd0, 11'd350);
    send(w_flat, 2'd1, 11'd350);
    send(w_diag, 2'd2, 11'd350);
    send(w_thr, 2'd0, 11'd350);
    send(w_thr, 2'd0, 11'd349);
    send(w_thr, 2'd3, 11'd349);
    drain();

    // Backpressure: six windows back-to-back with a four-cycle stall.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(mk(i*10, 3, 50+i, 7, 9, 200-i*20, 11, 90, 30+i*30), 2'd1, 11'd350);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("s_ready_full", int'(s_ready), 0);
        check("m_valid_stalled", int'(m_valid), 1);
        @(posedge clk); #1 m_ready = 1'b1;
      end
    join
    drain();

    // Three edges, then a clear coinciding with a fourth edge handshake.
    cnt_before = model_cnt;
    repeat (3) send(w_step, 2'd0, 11'd350);
    drain();
    @(negedge clk);
    check("edge_count_plus3", int'(edge_count), cnt_before + 3);
    @(posedge clk); #1;
    send(w_step, 2'd0, 11'd350);
    for (int c = 0; c < 10 && !m_valid; c++) begin
      @(posedge clk); #1;
    end
    check("clr_sync_valid", int'(m_valid), 1);
    clr_cnt = 1'b1;
    @(posedge clk); #1 clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_edge_count", int'(edge_count), 0);
    @(posedge clk); #1;

    // Reset with two pixels in flight: neither may ever appear.
    send(w_step, 2'd0, 11'd350);
    send(w_diag, 2'd2, 11'd350);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_reset_m_valid", int'(m_valid), 0);
    end
    check("post_reset_count", int'(edge_count), 0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure, modes and thresholds.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [9*PIX_W-1:0] w;
          for (int k = 0; k < 9; k++) w[k*PIX_W +: PIX_W] = 8'($urandom_range(0, 255));
          send(w, 2'($urandom_range(0, 3)), 11'($urandom_range(0, 1200)));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
        m_ready = 1'b1;
      end
    join
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
